// File: rtl/alt_vipcti131_fifo_stream_out_pkg.sv
// Shared definitions for the CVI FIFO read-side stream controller:
// controller states, FIFO word layout helpers and buffer depth.
package alt_vipcti131_fifo_stream_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    // Output buffer entries; fetch rule keeps occ + inflight within this.
    localparam int BUF_DEPTH = 3;

    // FIFO word layout: {sop, eop, data[DATA_WIDTH-1:0]}.
    function automatic int sop_pos(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int eop_pos(input int data_width);
        return data_width;
    endfunction

    // Number of bits needed to represent value (used to size fill levels).
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/alt_vipcti131_fifo_stream_out_buf.sv
// Three-entry register FIFO holding words ready for the Avalon-ST source.
// Entry 0 is always the head, so the head is a plain register output.
module alt_vipcti131_fifo_stream_out_buf
    import alt_vipcti131_fifo_stream_out_pkg::*;
#(
    parameter int WIDTH = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [1:0]       occ_q;
    logic [1:0]       occ_d;
    logic             pop_en;
    logic             push_en;
    logic [1:0]       wr_idx;

    // Pops only when something is held; pushes only when a slot is free
    // after this cycle's pop.
    assign pop_en  = pop && (occ_q != 2'd0);
    assign push_en = push && ((occ_q != 2'(BUF_DEPTH)) || pop_en);
    assign wr_idx  = occ_q - 2'(pop_en);
    assign occ_d   = occ_q + 2'(push_en) - 2'(pop_en);

    // Next contents: shift toward the head on pop, then write the new word
    // into the first free slot.
    always_comb begin
        for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (pop_en) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
        end
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (push_en && (wr_idx == 2'(i))) begin
                mem_d[i] = push_data;
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[0];

endmodule

// File: rtl/alt_vipcti131_fifo_stream_out.sv
// Read-side controller for the CVI common FIFO: fetches words from a
// 1-cycle-latency FIFO and presents them as an Avalon-ST video source,
// synchronising on sop and stopping only on packet boundaries.
module alt_vipcti131_fifo_stream_out
    import alt_vipcti131_fifo_stream_out_pkg::*;
#(
    parameter int DATA_WIDTH  = 20,
    parameter int FIFO_DEPTH  = 1920,
    parameter int DATA_WIDTHU = clogb2(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic                   fifo_rdreq,
    input  logic [DATA_WIDTH+1:0]  fifo_q,
    input  logic                   fifo_rdempty,
    input  logic [DATA_WIDTHU-1:0] fifo_rdusedw,
    input  logic                   dout_ready,
    output logic                   dout_valid,
    output logic [DATA_WIDTH-1:0]  dout_data,
    output logic                   dout_sop,
    output logic                   dout_eop,
    output logic                   stopped,
    output logic                   sync_error
);

    localparam int SOP_BIT = sop_pos(DATA_WIDTH);
    localparam int EOP_BIT = eop_pos(DATA_WIDTH);

    state_t               state_q;
    state_t               state_d;
    logic                 inflight_q;
    logic                 in_packet_q;
    logic                 in_packet_d;
    logic                 sync_error_q;
    logic                 word_sop;
    logic                 word_eop;
    logic                 accept;
    logic                 discard;
    logic                 pop;
    logic                 can_fetch;
    logic [2:0]           pending;
    logic [1:0]           buf_occ;
    logic [DATA_WIDTH+1:0] buf_head;
    logic                 unused_rdusedw;

    // Fill level is informational only for this controller.
    assign unused_rdusedw = ^fifo_rdusedw;

    assign word_sop = fifo_q[SOP_BIT];
    assign word_eop = fifo_q[EOP_BIT];

    // A returning word is kept if it starts or continues a packet.
    assign accept  = inflight_q && (in_packet_q || word_sop);
    assign discard = inflight_q && !in_packet_q && !word_sop;
    assign in_packet_d = accept ? !word_eop : in_packet_q;

    assign pop        = dout_valid && dout_ready;
    assign pending    = {1'b0, buf_occ} + {2'b00, inflight_q};
    assign can_fetch  = !fifo_rdempty && (pending <= 3'd2);

    // Next state and read request; reads start in the same cycle enable
    // is seen so the first word is valid two cycles later.
    always_comb begin
        state_d    = state_q;
        fifo_rdreq = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d    = ST_RUN;
                    fifo_rdreq = can_fetch;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    fifo_rdreq = can_fetch;
                end else if (in_packet_d) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FINISH: begin
                if (enable) begin
                    state_d    = ST_RUN;
                    fifo_rdreq = can_fetch;
                end else if (accept && word_eop) begin
                    state_d = ST_DRAIN;
                end else begin
                    // One word at a time so nothing past eop is fetched.
                    fifo_rdreq = can_fetch && !inflight_q;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d    = ST_RUN;
                    fifo_rdreq = can_fetch;
                end else if (!inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state, read pipeline, packet tracking and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            inflight_q   <= 1'b0;
            in_packet_q  <= 1'b0;
            sync_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= fifo_rdreq;
            in_packet_q  <= in_packet_d;
            sync_error_q <= sync_error_q || discard;
        end
    end

    alt_vipcti131_fifo_stream_out_buf #(
        .WIDTH(DATA_WIDTH + 2)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_data(fifo_q),
        .pop      (pop),
        .occ      (buf_occ),
        .head     (buf_head)
    );

    assign dout_valid = (buf_occ != 2'd0);
    assign dout_sop   = buf_head[SOP_BIT];
    assign dout_eop   = buf_head[EOP_BIT];
    assign dout_data  = buf_head[DATA_WIDTH-1:0];
    assign stopped    = (state_q == ST_IDLE) && (buf_occ == 2'd0) && !inflight_q;
    assign sync_error = sync_error_q;

endmodule

// File: tb/tb_alt_vipcti131_fifo_stream_out.sv
// Bench for the CVI FIFO stream-out controller: FIFO model, packet-level
// reference model with per-cycle compare, directed and random scenarios.
module tb_alt_vipcti131_fifo_stream_out;

    localparam int DW = 20;
    localparam int W  = DW + 2;
    localparam int UW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_rdreq;
    logic [W-1:0]  fifo_q = '0;
    logic          fifo_rdempty;
    logic [UW-1:0] fifo_rdusedw;
    logic          dout_ready = 1'b1;
    logic          dout_valid;
    logic [DW-1:0] dout_data;
    logic          dout_sop;
    logic          dout_eop;
    logic          stopped;
    logic          sync_error;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alt_vipcti131_fifo_stream_out #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (1920),
        .DATA_WIDTHU(UW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_rdreq  (fifo_rdreq),
        .fifo_q      (fifo_q),
        .fifo_rdempty(fifo_rdempty),
        .fifo_rdusedw(fifo_rdusedw),
        .dout_ready  (dout_ready),
        .dout_valid  (dout_valid),
        .dout_data   (dout_data),
        .dout_sop    (dout_sop),
        .dout_eop    (dout_eop),
        .stopped     (stopped),
        .sync_error  (sync_error)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- FIFO model (non-showahead, 1-cycle latency) --------
    logic [W-1:0] fmem [0:4095];
    int           wr_ptr = 0;
    int           rd_ptr = 0;
    logic         flush_req = 1'b0;

    assign fifo_rdempty = (wr_ptr == rd_ptr);
    assign fifo_rdusedw = UW'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (flush_req) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rdreq && (wr_ptr != rd_ptr)) begin
            fifo_q <= fmem[rd_ptr % 4096];
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic push_word(input logic s, input logic e, input logic [DW-1:0] d);
        fmem[wr_ptr % 4096] = {s, e, d};
        wr_ptr = wr_ptr + 1;
    endtask

    // ---------------- Reference model -------------------------------------
    // Words read from the FIFO return one cycle later; a word is delivered
    // if it is an sop or lies inside a packet, otherwise it is dropped and
    // raises the sticky error. Delivered words leave in order on handshake.
    logic [W-1:0] exp_q [$];
    logic         m_inflight = 1'b0;
    logic         m_in_pkt   = 1'b0;
    logic         m_err      = 1'b0;
    int           out_cnt    = 0;
    logic [W-1:0] got [0:255];

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_inflight <= 1'b0;
            m_in_pkt   <= 1'b0;
            m_err      <= 1'b0;
        end else begin
            if (dout_valid && dout_ready) begin
                got[out_cnt % 256] <= {dout_sop, dout_eop, dout_data};
                out_cnt <= out_cnt + 1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (m_inflight) begin
                if (m_in_pkt || fifo_q[W-1]) begin
                    exp_q.push_back(fifo_q);
                    m_in_pkt <= !fifo_q[W-2];
                end else begin
                    m_err <= 1'b1;
                end
            end
            m_inflight <= fifo_rdreq;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", 64'(dout_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0)
                chk("head", 64'({dout_sop, dout_eop, dout_data}), 64'(exp_q[0]));
            chk("sync_error", 64'(sync_error), 64'(m_err));
            chk("no_underflow", 64'(fifo_rdreq && fifo_rdempty), 64'd0);
            chk("occ_max", 64'(exp_q.size() <= 3), 64'd1);
            if (stopped)
                chk("stopped_empty", 64'(exp_q.size() + int'(m_inflight)), 64'd0);
        end
    end

    // ---------------- Stimulus helpers ------------------------------------
    task automatic wait_stopped(input string name);
        int n;
        n = 0;
        while (!stopped && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(stopped), 64'd1);
    endtask

    task automatic push_packet(input int len, input logic [DW-1:0] base);
        for (int k = 0; k < len; k++)
            push_word(k == 0, k == len - 1, base + DW'(k));
    endtask

    task automatic check_got(input string name, input int base_cnt, input int len,
                             input logic [DW-1:0] base);
        for (int k = 0; k < len; k++)
            chk(name, 64'(got[(base_cnt + k) % 256]),
                64'({k == 0, k == len - 1, base + DW'(k)}));
    endtask

    task automatic rand_step();
        @(negedge clk);
        dout_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) enable = !enable;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        logic [W-1:0] last_word;
        logic last_stall;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_stopped", 64'(stopped), 64'd1);
        chk("rst_sync", 64'(sync_error), 64'd0);
        chk("rst_rdreq", 64'(fifo_rdreq), 64'd0);

        // 1: 8-word packet, continuous ready, latency and throughput
        push_packet(8, 20'h00100);
        enable = 1'b1;
        @(negedge clk);
        chk("lat_c1", 64'(dout_valid), 64'd0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk("t1_valid", 64'(dout_valid), 64'd1);
            chk("t1_word", 64'({dout_sop, dout_eop, dout_data}),
                64'({k == 0, k == 7, 20'h00100 + 20'(k)}));
            @(negedge clk);
        end
        chk("t1_end", 64'(dout_valid), 64'd0);
        enable = 1'b0;
        wait_stopped("t1_stop");

        // 2: same packet with ready toggling
        base = out_cnt;
        push_packet(8, 20'h00200);
        enable = 1'b1;
        last_stall = 1'b0;
        last_word = '0;
        for (int c = 0; c < 60; c++) begin
            if (last_stall)
                chk("t2_stable", 64'({dout_sop, dout_eop, dout_data}), 64'(last_word));
            last_stall = dout_valid && !dout_ready;
            last_word  = {dout_sop, dout_eop, dout_data};
            @(negedge clk);
            dout_ready = !dout_ready;
        end
        dout_ready = 1'b1;
        chk("t2_count", 64'(out_cnt - base), 64'd8);
        check_got("t2_seq", base, 8, 20'h00200);
        enable = 1'b0;
        wait_stopped("t2_stop");

        // 3: drop enable mid-packet; packet completes, next sop stays queued
        base = out_cnt;
        push_packet(8, 20'h00300);
        push_packet(2, 20'h003F0);
        enable = 1'b1;
        n = 0;
        while ((out_cnt - base) < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        enable = 1'b0;
        wait_stopped("t3_stop");
        chk("t3_count", 64'(out_cnt - base), 64'd8);
        check_got("t3_seq", base, 8, 20'h00300);
        chk("t3_left", 64'(wr_ptr - rd_ptr), 64'd2);
        repeat (5) begin
            @(negedge clk);
            chk("t3_no_read", 64'(fifo_rdreq), 64'd0);
        end
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;

        // 4: orphans ahead of a packet
        base = out_cnt;
        push_word(1'b0, 1'b0, 20'h00AAA);
        push_word(1'b0, 1'b1, 20'h00BBB);
        push_packet(4, 20'h00400);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        chk("t4_sync", 64'(sync_error), 64'd1);
        chk("t4_count", 64'(out_cnt - base), 64'd4);
        check_got("t4_seq", base, 4, 20'h00400);
        enable = 1'b0;
        wait_stopped("t4_stop");

        // 5: reset while the buffer is full
        push_packet(8, 20'h00500);
        dout_ready = 1'b0;
        enable = 1'b1;
        repeat (8) @(negedge clk);
        chk("t5_full_valid", 64'(dout_valid), 64'd1);
        chk("t5_full_rdreq", 64'(fifo_rdreq), 64'd0);
        rst = 1'b1;
        enable = 1'b0;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        chk("t5_valid", 64'(dout_valid), 64'd0);
        chk("t5_stopped", 64'(stopped), 64'd1);
        chk("t5_sync", 64'(sync_error), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        base = out_cnt;
        push_packet(4, 20'h00550);
        enable = 1'b1;
        repeat (12) @(negedge clk);
        chk("t5_count", 64'(out_cnt - base), 64'd4);
        check_got("t5_seq", base, 4, 20'h00550);
        enable = 1'b0;
        wait_stopped("t5_stop");

        // 6: FIFO runs empty mid-packet
        base = out_cnt;
        for (int k = 0; k < 3; k++) push_word(k == 0, 1'b0, 20'h00600 + 20'(k));
        enable = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_gap", 64'(dout_valid), 64'd0);
        repeat (5) @(negedge clk);
        for (int k = 3; k < 6; k++) push_word(1'b0, k == 5, 20'h00600 + 20'(k));
        repeat (10) @(negedge clk);
        chk("t6_count", 64'(out_cnt - base), 64'd6);
        check_got("t6_seq", base, 6, 20'h00600);
        chk("t6_sync", 64'(sync_error), 64'd0);
        enable = 1'b0;
        wait_stopped("t6_stop");

        // 7: random packets, orphans, truncations, ready and enable noise
        enable = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            logic trunc;
            if ($urandom_range(0, 7) == 0) begin
                push_word(1'b0, 1'($urandom_range(0, 1)), DW'($urandom));
                rand_step();
            end
            len = $urandom_range(1, 6);
            trunc = (p != 39) && ($urandom_range(0, 9) == 0);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) rand_step();
                push_word(k == 0, (k == len - 1) && !trunc, DW'($urandom));
                rand_step();
            end
        end
        enable = 1'b1;
        dout_ready = 1'b1;
        n = 0;
        while (((wr_ptr != rd_ptr) || (exp_q.size() != 0) || m_inflight) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rand_drain", 64'(n < 500), 64'd1);
        enable = 1'b0;
        wait_stopped("rand_stop");
        chk("rand_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
